// File: rtl/motorpwm.sv
// Right-motor H-bridge drive stage: input synchronizer, dead-time on direction start/reversal,
// linear soft-start PWM duty ramp and free-running PWM modulation of the bridge enable.
module motorpwm #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned DUTY_MAX = 255,
  parameter int unsigned RAMP_DIV = 64,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en1,
  input  logic                in1,
  input  logic                in2,
  output logic                drv_in1,
  output logic                drv_in2,
  output logic                pwm_en,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int unsigned DeadW = $clog2(DEAD_CYC + 1);
  localparam int unsigned RampW = $clog2(RAMP_DIV + 1);
  localparam logic [DeadW-1:0]    DeadLast = DeadW'(DEAD_CYC - 1);
  localparam logic [RampW-1:0]    RampLast = RampW'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DutyPre  = PWM_BITS'(DUTY_MAX - 1);

  typedef enum logic [1:0] {StIdle, StDead, StRamp, StRun} state_e;

  state_e              state_q;
  logic [2:0]          sync1_q, sync2_q;  // {en1, in1, in2}
  logic                dir_q;             // 1 = forward, 0 = reverse
  logic                brake_q;
  logic [DeadW-1:0]    dead_cnt_q;
  logic [RampW-1:0]    ramp_cnt_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;

  logic cmd_fwd, cmd_rev, cmd_drive, cmd_brake, cmd_opp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {en1, in1, in2};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cmd_fwd   = sync2_q[2] & sync2_q[1] & ~sync2_q[0];
    cmd_rev   = sync2_q[2] & ~sync2_q[1] & sync2_q[0];
    cmd_brake = sync2_q[2] & (sync2_q[1] == sync2_q[0]);
    cmd_drive = cmd_fwd | cmd_rev;
    cmd_opp   = cmd_drive & (cmd_fwd != dir_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      brake_q    <= 1'b0;
      dead_cnt_q <= '0;
      ramp_cnt_q <= '0;
      duty_q     <= '0;
    end else begin
      // Brake is only visible in IDLE, so tracking it unconditionally keeps it aligned with state.
      brake_q <= cmd_brake;
      unique case (state_q)
        StIdle: begin
          if (cmd_drive) begin
            state_q    <= StDead;
            dir_q      <= cmd_fwd;
            dead_cnt_q <= '0;
          end
        end
        StDead: begin
          if (!cmd_drive) begin
            state_q <= StIdle;
          end else if (cmd_opp) begin
            dir_q      <= cmd_fwd;
            dead_cnt_q <= '0;
          end else if (dead_cnt_q == DeadLast) begin
            state_q    <= StRamp;
            duty_q     <= '0;
            ramp_cnt_q <= '0;
          end else begin
            dead_cnt_q <= dead_cnt_q + DeadW'(1);
          end
        end
        StRamp, StRun: begin
          if (!cmd_drive) begin
            state_q <= StIdle;
            duty_q  <= '0;
          end else if (cmd_opp) begin
            state_q    <= StDead;
            dir_q      <= cmd_fwd;
            dead_cnt_q <= '0;
            duty_q     <= '0;
          end else if (state_q == StRamp) begin
            if (ramp_cnt_q == RampLast) begin
              ramp_cnt_q <= '0;
              duty_q     <= duty_q + PWM_BITS'(1);
              if (duty_q == DutyPre) state_q <= StRun;
            end else begin
              ramp_cnt_q <= ramp_cnt_q + RampW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs depend on registers only; no combinational path from the command inputs.
  always_comb begin
    drv_in1 = 1'b0;
    drv_in2 = 1'b0;
    pwm_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        drv_in1 = brake_q;
        drv_in2 = brake_q;
        pwm_en  = brake_q;
      end
      StDead: ;
      StRamp, StRun: begin
        drv_in1 = dir_q;
        drv_in2 = ~dir_q;
        pwm_en  = (pwm_cnt_q < duty_q);
      end
      default: ;
    endcase
    duty = duty_q;
    busy = (state_q == StDead) || (state_q == StRamp);
  end

endmodule

// File: tb/tb_motorpwm.sv
// Bench for motorpwm: elapsed-time behavioural model compared every cycle, directed scenarios
// with literal expectations, then randomized command sequences with occasional async resets.
module tb_motorpwm;

  localparam int PB = 4, DMAX = 12, RDIV = 2, DCYC = 3, PER = 16;

  logic          clk, rst_n, en1, in1, in2;
  logic          drv_in1, drv_in2, pwm_en, busy;
  logic [PB-1:0] duty;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 idle, 1 dead, 2 ramp, 3 run; m_t = edges since entering the mode.
  int         m_mode, m_t, m_tick;
  bit         m_dir, m_brake;
  logic [2:0] m_s1, m_s2;

  motorpwm #(.PWM_BITS(PB), .DUTY_MAX(DMAX), .RAMP_DIV(RDIV), .DEAD_CYC(DCYC)) dut (
    .clk(clk), .rst_n(rst_n), .en1(en1), .in1(in1), .in2(in2),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .pwm_en(pwm_en), .duty(duty), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {drv_in1, drv_in2, pwm_en, busy, duty};
  endfunction

  function automatic logic [7:0] model_vec();
    int d;
    bit a, b, pe, bz;
    d  = (m_mode == 2) ? m_t / RDIV : ((m_mode == 3) ? DMAX : 0);
    bz = (m_mode == 1) || (m_mode == 2);
    case (m_mode)
      0:       begin a = m_brake; b = m_brake; pe = m_brake; end
      1:       begin a = 0; b = 0; pe = 0; end
      default: begin a = m_dir; b = !m_dir; pe = (m_tick < d); end
    endcase
    return {a, b, pe, bz, 4'(d)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_tick = 0; m_dir = 0; m_brake = 0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_step();
    bit en, fwd, rev, drive;
    en    = m_s2[2];
    fwd   = en && m_s2[1] && !m_s2[0];
    rev   = en && !m_s2[1] && m_s2[0];
    drive = fwd || rev;
    case (m_mode)
      0: if (drive) begin m_mode = 1; m_t = 0; m_dir = fwd; end
      1: begin
        if (!drive) m_mode = 0;
        else if (fwd != m_dir) begin m_t = 0; m_dir = fwd; end
        else begin
          m_t++;
          if (m_t == DCYC) begin m_mode = 2; m_t = 0; end
        end
      end
      default: begin
        if (!drive) m_mode = 0;
        else if (fwd != m_dir) begin m_mode = 1; m_t = 0; m_dir = fwd; end
        else if (m_mode == 2) begin
          m_t++;
          if (m_t == DMAX * RDIV) m_mode = 3;
        end
      end
    endcase
    m_brake = en && (m_s2[1] == m_s2[0]);
    m_tick  = (m_tick + 1) % PER;
    m_s2    = m_s1;
    m_s1    = {en1, in1, in2};
  endtask

  // One clock: advance the model on the rising edge, compare everything on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic set_cmd(input logic e, input logic a, input logic b);
    en1 = e; in1 = a; in2 = b;
  endtask

  // Called at a falling edge; reset lands mid-phase, away from any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", dut_vec(), 0);
    model_reset();
  endtask

  initial begin
    int hi, bs, len, r;
    model_reset();
    rst_n = 1'b0;
    set_cmd(0, 0, 0);
    repeat (2) cyc();
    check("reset_state", dut_vec(), 0);
    rst_n = 1'b1;
    repeat (4) cyc();

    // Forward start from coast
    set_cmd(1, 1, 0);
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (i == 2) check("fwd_latency_idle", busy, 0);
      if (i == 3) check("fwd_dead_entry", dut_vec(), 8'h10);
      if (i == 5) check("fwd_dead_last", dut_vec(), 8'h10);
      if (i == 6) begin
        check("fwd_ramp_dir", {drv_in1, drv_in2}, 2'b10);
        check("fwd_ramp_duty0", duty, 0);
      end
      if (i == 8) check("fwd_ramp_duty1", duty, 1);
      if (i == 29) begin
        check("fwd_ramp_duty11", duty, 11);
        check("fwd_ramp_busy", busy, 1);
      end
      if (i == 30) begin
        check("fwd_run_duty", duty, DMAX);
        check("fwd_run_busy", busy, 0);
      end
    end
    hi = 0;
    repeat (16) begin
      cyc();
      hi += int'(pwm_en);
    end
    check("run_pwm_high_time", hi, 12);

    // Reversal from RUN forward
    set_cmd(1, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 2) check("rev_still_fwd", {drv_in1, drv_in2}, 2'b10);
      if (i == 3) check("rev_dead_entry", dut_vec(), 8'h10);
      if (i == 5) check("rev_dead_last", dut_vec(), 8'h10);
      if (i == 6) begin
        check("rev_ramp_dir", {drv_in1, drv_in2}, 2'b01);
        check("rev_ramp_duty0", duty, 0);
      end
    end
    repeat (26) cyc();
    check("rev_run_duty", duty, DMAX);

    // Async reset mid-RUN, release with brake
    async_reset();
    set_cmd(1, 1, 1);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_brake_edge1", pwm_en, 0);
    cyc();
    check("rst_brake_edge2", pwm_en, 0);
    cyc();
    check("rst_brake_edge3", dut_vec(), 8'hE0);

    // Stop mid-ramp with brake, then coast
    set_cmd(1, 1, 0);
    for (int i = 0; i < 60 && duty != 5; i++) cyc();
    check("reach_duty5", duty, 5);
    set_cmd(1, 1, 1);
    repeat (3) cyc();
    check("stop_brake", dut_vec(), 8'hE0);
    set_cmd(0, 0, 0);
    repeat (3) cyc();
    check("stop_coast", dut_vec(), 0);

    // Glitch that never spans a clock edge
    #1 set_cmd(1, 1, 0);
    #2 set_cmd(0, 0, 0);
    bs = 0;
    repeat (6) begin
      cyc();
      bs |= int'(busy);
    end
    check("glitch1_no_dead", bs, 0);

    // FWD held for two edges
    set_cmd(1, 1, 0);
    repeat (2) cyc();
    set_cmd(0, 0, 0);
    bs = 0;
    repeat (6) begin
      cyc();
      bs |= int'(busy);
    end
    check("glitch2_dead_seen", bs, 1);
    check("glitch2_back_idle", dut_vec(), 0);

    // Reversal during DEAD restarts the dead time
    set_cmd(1, 1, 0);
    cyc();
    set_cmd(1, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 2) check("dead_rev_in_dead", busy, 1);
      if (i == 5) check("dead_rev_restart", dut_vec(), 8'h10);
      if (i == 6) check("dead_rev_ramp_dir", {drv_in1, drv_in2}, 2'b01);
    end

    // Randomized command sequences
    for (int s = 0; s < 150; s++) begin
      r   = $urandom_range(0, 9);
      len = $urandom_range(1, 40);
      if (r <= 6 && $urandom_range(0, 3) == 0) len += 40;
      case (r)
        0, 1, 2, 3: set_cmd(1, 1, 0);
        4, 5, 6:    set_cmd(1, 0, 1);
        7:          set_cmd(1, 1, 1);
        8:          set_cmd(0, 0, 0);
        default:    set_cmd(1'($urandom), 1'($urandom), 1'($urandom));
      endcase
      if ($urandom_range(0, 29) == 0) begin
        async_reset();
        cyc();
        rst_n = 1'b1;
      end
      repeat (len) cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
